flash_test_seq_gen: RTL

- Parametrised successor to the fixed erase/write/read user generator for the SPI flash controller.
- Runs P_PAGE_NUM iterations of sector erase (when needed), page write and read-back over a configurable address range.
- Generates a selectable data pattern and checks every read byte against it.
- Reports busy, done, pass and an error count; sits between top-level control and the flash controller op/data interface.

---
 rtl/flash_pkg.sv | 29 ++
 rtl/flash_pattern_gen.sv | 24 ++
 rtl/flash_test_seq_gen.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/flash_pkg.sv
// Shared constants and FSM encoding for the flash test sequence generator.
package flash_pkg;

  // Controller op type encoding
  localparam logic [1:0] OP_ERASE = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;

  localparam int unsigned SECTOR_SIZE = 4096;

  // Data pattern modes
  localparam logic [1:0] PAT_SEED_K = 2'd0;  // seed + k
  localparam logic [1:0] PAT_INV    = 2'd1;  // ~(seed + k)
  localparam logic [1:0] PAT_PAGE   = 2'd2;  // seed + k + page

  typedef enum logic [3:0] {
    StIdle,
    StEraseReq,
    StEraseWait,
    StWriteReq,
    StWriteData,
    StWriteWait,
    StReadReq,
    StReadWait,
    StNext,
    StDone
  } state_t;

endpackage

// File: rtl/flash_pattern_gen.sv
// Combinational test-data pattern: byte k of a page for a given seed and mode.
module flash_pattern_gen
  import flash_pkg::*;
(
  input  logic [7:0] seed,
  input  logic [1:0] mode,
  input  logic [7:0] page,
  input  logic [7:0] index,
  output logic [7:0] data
);

  logic [7:0] sum;

  // Select the pattern variant; all arithmetic wraps mod 256.
  always_comb begin
    sum = seed + index;
    case (mode)
      PAT_INV:  data = ~sum;
      PAT_PAGE: data = sum + page;
      default:  data = sum;
    endcase
  end

endmodule

// File: rtl/flash_test_seq_gen.sv
// Erase/write/read-back test sequencer for the SPI flash controller op interface.
module flash_test_seq_gen
  import flash_pkg::*;
#(
  parameter logic [23:0] P_BASE_ADDR    = 24'h000000,
  parameter int unsigned P_ADDR_STEP    = 256,
  parameter int unsigned P_LEN          = 8,
  parameter int unsigned P_PAGE_NUM     = 4,
  parameter int unsigned P_PATTERN_MODE = 0,
  parameter logic [7:0]  P_SEED         = 8'h00,
  parameter bit          P_ERASE_EN     = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_op_ready,
  input  logic [7:0]  i_read_data,
  input  logic        i_read_sop,
  input  logic        i_read_eop,
  input  logic        i_read_valid,
  output logic [1:0]  o_op_typ,
  output logic [23:0] o_op_addr,
  output logic [8:0]  o_op_num,
  output logic        o_op_valid,
  output logic [7:0]  o_write_data,
  output logic        o_write_sop,
  output logic        o_write_eop,
  output logic        o_write_valid,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_pass,
  output logic [15:0] o_err_cnt,
  output logic [15:0] o_cur_page
);

  localparam logic [8:0]  LEN9      = 9'(P_LEN);
  localparam logic [15:0] LAST_PAGE = 16'(P_PAGE_NUM - 1);
  localparam logic [23:0] STEP24    = 24'(P_ADDR_STEP);
  localparam logic [1:0]  MODE2     = 2'(P_PATTERN_MODE);

  state_t      state_q;
  logic [23:0] addr_q;
  logic [8:0]  wr_k_q;
  logic [8:0]  rd_cnt_q;
  logic        ready_q;
  logic        ready_q2;

  logic [23:0] addr_next;
  logic        erase_next;
  logic        ready_rise;
  logic        accept;
  logic [8:0]  rd_idx;
  logic [8:0]  rd_cnt_after;
  logic [1:0]  err_inc;
  logic [16:0] err_sum;
  logic [15:0] err_next;
  logic [7:0]  wr_pat;
  logic [7:0]  rd_pat;

  // Read framing is tracked by sop and op completion; eop carries no extra information here.
  logic unused_read_eop;
  assign unused_read_eop = i_read_eop;

  flash_pattern_gen u_wr_pat (
    .seed  (P_SEED),
    .mode  (MODE2),
    .page  (o_cur_page[7:0]),
    .index (wr_k_q[7:0]),
    .data  (wr_pat)
  );

  flash_pattern_gen u_rd_pat (
    .seed  (P_SEED),
    .mode  (MODE2),
    .page  (o_cur_page[7:0]),
    .index (rd_idx[7:0]),
    .data  (rd_pat)
  );

  // Next-page address, erase decision, completion edge and read-check error increment.
  always_comb begin
    addr_next  = addr_q + STEP24;
    erase_next = P_ERASE_EN &&
                 ((addr_next[11:0] == 12'h000) || (addr_next[23:12] != addr_q[23:12]));
    ready_rise = ready_q & ~ready_q2;
    accept     = o_op_valid & i_op_ready;

    rd_idx       = i_read_sop ? 9'd0 : rd_cnt_q;
    rd_cnt_after = rd_cnt_q;
    err_inc      = 2'd0;
    if (state_q == StReadWait) begin
      if (i_read_valid) begin
        // Beats past the op length are errors in their own right and are not compared.
        if (rd_idx < LEN9) begin
          rd_cnt_after = rd_idx + 9'd1;
          if (rd_pat != i_read_data) err_inc = err_inc + 2'd1;
        end else begin
          rd_cnt_after = rd_idx;
          err_inc      = err_inc + 2'd1;
        end
      end
      // Count includes a beat landing in the completion cycle.
      if (ready_rise && (rd_cnt_after != LEN9)) err_inc = err_inc + 2'd1;
    end
    err_sum  = {1'b0, o_err_cnt} + {15'd0, err_inc};
    err_next = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      wr_k_q        <= '0;
      rd_cnt_q      <= '0;
      ready_q       <= 1'b0;
      ready_q2      <= 1'b0;
      o_op_typ      <= '0;
      o_op_addr     <= '0;
      o_op_num      <= '0;
      o_op_valid    <= 1'b0;
      o_write_data  <= '0;
      o_write_sop   <= 1'b0;
      o_write_eop   <= 1'b0;
      o_write_valid <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_pass        <= 1'b0;
      o_err_cnt     <= '0;
      o_cur_page    <= '0;
    end else begin
      ready_q  <= i_op_ready;
      ready_q2 <= ready_q;
      unique case (state_q)
        StIdle: begin
          if (i_start) begin
            o_err_cnt  <= '0;
            o_pass     <= 1'b0;
            o_cur_page <= '0;
            o_busy     <= 1'b1;
            addr_q     <= P_BASE_ADDR;
            o_op_valid <= 1'b1;
            if (P_ERASE_EN) begin
              state_q   <= StEraseReq;
              o_op_typ  <= OP_ERASE;
              o_op_addr <= {P_BASE_ADDR[23:12], 12'h000};
              o_op_num  <= '0;
            end else begin
              state_q   <= StWriteReq;
              o_op_typ  <= OP_WRITE;
              o_op_addr <= P_BASE_ADDR;
              o_op_num  <= LEN9;
              wr_k_q    <= '0;
            end
          end
        end
        StEraseReq: begin
          if (accept) begin
            o_op_valid <= 1'b0;
            state_q    <= StEraseWait;
          end
        end
        StEraseWait: begin
          if (ready_rise) begin
            state_q    <= StWriteReq;
            o_op_typ   <= OP_WRITE;
            o_op_addr  <= addr_q;
            o_op_num   <= LEN9;
            o_op_valid <= 1'b1;
            wr_k_q     <= '0;
          end
        end
        StWriteReq: begin
          if (accept) begin
            o_op_valid    <= 1'b0;
            o_write_valid <= 1'b1;
            o_write_data  <= wr_pat;
            o_write_sop   <= 1'b1;
            o_write_eop   <= (LEN9 == 9'd1);
            wr_k_q        <= 9'd1;
            state_q       <= StWriteData;
          end
        end
        StWriteData: begin
          if (wr_k_q == LEN9) begin
            o_write_valid <= 1'b0;
            o_write_sop   <= 1'b0;
            o_write_eop   <= 1'b0;
            state_q       <= StWriteWait;
          end else begin
            o_write_data <= wr_pat;
            o_write_sop  <= 1'b0;
            o_write_eop  <= (wr_k_q == LEN9 - 9'd1);
            wr_k_q       <= wr_k_q + 9'd1;
          end
        end
        StWriteWait: begin
          if (ready_rise) begin
            state_q    <= StReadReq;
            o_op_typ   <= OP_READ;
            o_op_addr  <= addr_q;
            o_op_num   <= LEN9;
            o_op_valid <= 1'b1;
            rd_cnt_q   <= '0;
          end
        end
        StReadReq: begin
          if (accept) begin
            o_op_valid <= 1'b0;
            state_q    <= StReadWait;
          end
        end
        StReadWait: begin
          rd_cnt_q  <= rd_cnt_after;
          o_err_cnt <= err_next;
          if (ready_rise) state_q <= StNext;
        end
        StNext: begin
          if (o_cur_page == LAST_PAGE) begin
            state_q <= StDone;
            o_done  <= 1'b1;
            o_pass  <= (o_err_cnt == 16'd0);
          end else begin
            o_cur_page <= o_cur_page + 16'd1;
            addr_q     <= addr_next;
            o_op_valid <= 1'b1;
            if (erase_next) begin
              state_q   <= StEraseReq;
              o_op_typ  <= OP_ERASE;
              o_op_addr <= {addr_next[23:12], 12'h000};
              o_op_num  <= '0;
            end else begin
              state_q   <= StWriteReq;
              o_op_typ  <= OP_WRITE;
              o_op_addr <= addr_next;
              o_op_num  <= LEN9;
              wr_k_q    <= '0;
            end
          end
        end
        StDone: begin
          o_done  <= 1'b0;
          o_busy  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
